// File: rtl/bascomp_pkg.sv
// ---------------------------------------------------------------------------
// bascomp_pkg
//
// Purpose:
//   Shared definitions for the basic-computer control unit. Holds the default
//   geometry of the instruction-cycle sequence counter and the encoding of the
//   per-edge control decision (clear / load / count / hold), so that the
//   counter and any control logic that reasons about it agree on the
//   priority order.
//
// Contents:
//   SEQ_WIDTH_DEF  default counter width in bits
//   SEQ_MAX_DEF    default terminal count (full 4-bit range)
//   seq_ctrl_e     control decision, listed in priority order
//   seqCtrlSelect  resolves the raw clr/ld/inc strobes into one decision
//
// Configuration macros: none.
// ---------------------------------------------------------------------------
package bascomp_pkg;

  localparam int SEQ_WIDTH_DEF = 4;
  localparam int SEQ_MAX_DEF   = 15;

  // The enumerators are listed highest priority first; the encoding itself
  // carries no meaning beyond distinguishing the four cases.
  typedef enum logic [1:0] {
    SEQ_CLR  = 2'd0,
    SEQ_LD   = 2'd1,
    SEQ_INC  = 2'd2,
    SEQ_HOLD = 2'd3
  } seq_ctrl_e;

  // Collapses the three control strobes into a single decision. Clear beats
  // load, load beats counting, and with nothing asserted the counter holds.
  // Direction is not part of the decision; it only matters once SEQ_INC has
  // been chosen.
  function automatic seq_ctrl_e seqCtrlSelect(input logic clr,
                                              input logic ld,
                                              input logic inc);
    seq_ctrl_e sel;
    if (clr) begin
      sel = SEQ_CLR;
    end else if (ld) begin
      sel = SEQ_LD;
    end else if (inc) begin
      sel = SEQ_INC;
    end else begin
      sel = SEQ_HOLD;
    end
    return sel;
  endfunction

endpackage : bascomp_pkg

// File: rtl/seq_onehot_decoder.sv
// ---------------------------------------------------------------------------
// seq_onehot_decoder
//
// Purpose:
//   Turns the binary step count into the one-hot timing signals T0..T(N-1)
//   used by the control logic. Purely combinational, so the timing signals
//   change in the same cycle as the count with no added latency.
//
// Parameters:
//   WIDTH  width of the incoming count
//   N      number of timing signals (terminal count + 1)
//
// Ports:
//   count  in   WIDTH  current step from the sequence counter
//   t      out  N      one-hot decode, t[i] = (count == i)
//
// Configuration macros:
//   SEQ_DECODE_EN  the module is only compiled when this macro is defined,
//                  since the counter instantiates it only in that build.
// ---------------------------------------------------------------------------
`ifdef SEQ_DECODE_EN
module seq_onehot_decoder #(
  parameter int WIDTH = 4,
  parameter int N     = 16
) (
  input  logic [WIDTH-1:0] count,
  output logic [N-1:0]     t
);

  // Each output bit is an equality compare against its own index. The
  // counter never presents a value of N or above, so exactly one bit is set
  // at all times; no fallback for out-of-range counts is needed.
  always_comb begin
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (count == WIDTH'(i)) begin
        t[i] = 1'b1;
      end
    end
  end

endmodule : seq_onehot_decoder
`endif

// File: rtl/seq_timing_counter.sv
// ---------------------------------------------------------------------------
// seq_timing_counter
//
// Purpose:
//   Instruction-cycle sequence counter for the basic-computer control unit.
//   Counts 0..MAX_COUNT and wraps, in either direction, with synchronous
//   clear and load, and reports each wrap with a one-cycle registered pulse.
//   Optionally provides the one-hot timing signals T0..T(MAX_COUNT).
//
// Parameters:
//   WIDTH      counter width in bits, 2..8
//   MAX_COUNT  terminal count, 1..2**WIDTH-1; the count wraps after it
//
// Ports:
//   clk     in   1            system clock, rising edge
//   rst     in   1            asynchronous active-high reset
//   clr     in   1            synchronous clear to 0 (highest priority)
//   ld      in   1            synchronous load of ld_val (clamped)
//   ld_val  in   WIDTH        load value
//   inc     in   1            count enable
//   dn      in   1            direction when counting: 0 up, 1 down
//   count   out  WIDTH        registered current step
//   wrap    out  1            registered pulse: the previous edge wrapped
//   t       out  MAX_COUNT+1  one-hot timing signals (SEQ_DECODE_EN only)
//
// Configuration macros:
//   SEQ_DECODE_EN  when defined, port t and the one-hot decoder are built in;
//                  otherwise they are absent and count/wrap are unchanged.
// ---------------------------------------------------------------------------
module seq_timing_counter
  import bascomp_pkg::*;
#(
  parameter int WIDTH     = SEQ_WIDTH_DEF,
  parameter int MAX_COUNT = SEQ_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  input  logic             dn,
  output logic [WIDTH-1:0] count
`ifdef SEQ_DECODE_EN
  ,
  output logic             wrap,
  output logic [MAX_COUNT:0] t
`else
  ,
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH-1:0] ldClamped;
  seq_ctrl_e        ctrlSel;

  // Resolve this edge's action once, in priority order, so the next-state
  // logic below only has to deal with one case at a time.
  always_comb begin
    ctrlSel = seqCtrlSelect(clr, ld, inc);
  end

  // Loads above the terminal count would put the counter into a state it
  // could never leave cleanly, so they are pinned to MAX_COUNT instead.
  // There is deliberately no error indication for this.
  always_comb begin
    ldClamped = ld_val;
    if (ld_val > MAX_VAL) begin
      ldClamped = MAX_VAL;
    end
  end

  // Next-state logic for the count and the wrap pulse. Both wrap points are
  // detected with an explicit compare rather than by letting the adder
  // overflow: that makes a short sequence (MAX_COUNT below the full range)
  // wrap correctly, and for the full range it gives the same answer as the
  // natural overflow would. Every path other than a counting wrap drives
  // wrap low, which is what makes it a one-cycle pulse.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    unique case (ctrlSel)
      SEQ_CLR: begin
        count_d = '0;
      end
      SEQ_LD: begin
        count_d = ldClamped;
      end
      SEQ_INC: begin
        if (dn) begin
          if (count_q == '0) begin
            count_d = MAX_VAL;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - ONE_VAL;
          end
        end else begin
          if (count_q == MAX_VAL) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + ONE_VAL;
          end
        end
      end
      SEQ_HOLD: begin
        count_d = count_q;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // State register. Reset is asynchronous so the control unit sees step 0
  // (and T0) the moment reset is raised, without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Outputs come straight from the registers, so count and wrap never
  // glitch with the control inputs.
  always_comb begin
    count = count_q;
    wrap  = wrap_q;
  end

`ifdef SEQ_DECODE_EN
  // The timing signals are decoded from the registered count, so they carry
  // no extra latency and follow the async reset to T0 immediately.
  seq_onehot_decoder #(
    .WIDTH (WIDTH),
    .N     (MAX_COUNT + 1)
  ) uDecoder (
    .count (count_q),
    .t     (t)
  );
`endif

endmodule : seq_timing_counter
